seq_detect_arbiter: RTL

// - Shares one serial Moore pattern-detector core among N_REQ requesters.
// - Round-robin grants one requester, clears the core, shifts its WORD_W-bit word in MSB-first (one bit/clk),

---
 rtl/seq_detect_pkg.sv | 29 ++
 rtl/seq_detect_core.sv | 44 ++++
 rtl/seq_detect_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/seq_detect_pkg.sv
// Shared types for the round-robin serial pattern-detector arbiter.
// No logic; state encodings for the service FSM and the Moore detector core.
// No flow control of its own.
package seq_detect_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      SHIFT = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } arb_state_t;

   // S0 no useful history, S1 "..01" (not 101), S2 "..11", S3 "010"/"10",
   // S4 "110" (hit), S5 "101" (hit)
   typedef enum logic [2:0] {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      S4 = 3'd4,
      S5 = 3'd5
   } core_state_t;

   function automatic logic core_hit(input core_state_t s);
      return (s == S4) || (s == S5);
   endfunction

endpackage

// File: rtl/seq_detect_core.sv
// Moore detector: out=1 when the last three bits shifted are 110 or 101 (overlapping).
// Latency: out reflects the bit shifted on the previous clock edge.
// Backpressure: none; en gates advancement, sclr returns to S0 synchronously.
module seq_detect_core
   import seq_detect_pkg::*;
(
   input  logic clk,
   input  logic clr,
   input  logic sclr,
   input  logic en,
   input  logic w,
   output logic out
);

   core_state_t r_state;
   core_state_t w_next;

   // next-state: sync clear wins, otherwise advance only when enabled
   always_comb begin
      w_next = r_state;
      if (sclr) begin
         w_next = S0;
      end else if (en) begin
         case (r_state)
            S0:      w_next = w ? S1 : S0;
            S1:      w_next = w ? S2 : S3;
            S2:      w_next = w ? S2 : S4;
            S3:      w_next = w ? S5 : S0;
            S4:      w_next = w ? S5 : S0;
            S5:      w_next = w ? S2 : S3;
            default: w_next = S0;
         endcase
      end
   end

   // state register with asynchronous active-low reset
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) r_state <= S0;
      else      r_state <= w_next;
   end

   assign out = core_hit(r_state);

endmodule

// File: rtl/seq_detect_arbiter.sv
// Round-robin shares one serial detector among N_REQ requesters; returns hit count (HIT_MASK_EN adds hit_mask).
// Latency: grant to done is WORD_W+3 clocks; busy covers LOAD through DONE inclusive.
// Backpressure: requesters hold req/data until their one-cycle ack; one word in service at a time.
module seq_detect_arbiter
   import seq_detect_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int WORD_W = 8,
   parameter int CNT_W  = $clog2(WORD_W + 1)
)(
   input  logic                       clk,
   input  logic                       clr,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ*WORD_W-1:0]    data,
   output logic [N_REQ-1:0]           ack,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(N_REQ)-1:0]   done_id,
   output logic [CNT_W-1:0]           hit_cnt
`ifdef HIT_MASK_EN
   ,output logic [WORD_W-1:0]         hit_mask
`endif
);

   localparam int ID_W = $clog2(N_REQ);

   arb_state_t        r_state;
   arb_state_t        w_next;
   logic [ID_W-1:0]   r_ptr;
   logic [ID_W-1:0]   r_id;
   logic [WORD_W-1:0] r_word;
   logic [CNT_W-1:0]  r_bit;
   logic [CNT_W-1:0]  r_hit_cnt;

   logic              w_hi_vld;
   logic [ID_W-1:0]   w_hi_id;
   logic              w_lo_vld;
   logic [ID_W-1:0]   w_lo_id;
   logic              w_gnt_vld;
   logic [ID_W-1:0]   w_gnt_id;
   logic [WORD_W-1:0] w_word;
   logic              w_core_sclr;
   logic              w_core_en;
   logic              w_core_out;
   logic              w_sample;

   // round-robin pick: lowest set req above the pointer, else lowest set req overall (wrap)
   always_comb begin
      w_hi_vld = 1'b0;
      w_hi_id  = '0;
      w_lo_vld = 1'b0;
      w_lo_id  = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            w_lo_vld = 1'b1;
            w_lo_id  = ID_W'(i);
            if (ID_W'(i) > r_ptr) begin
               w_hi_vld = 1'b1;
               w_hi_id  = ID_W'(i);
            end
         end
      end
      w_gnt_vld = w_lo_vld;
      w_gnt_id  = w_hi_vld ? w_hi_id : w_lo_id;
   end

   // select the granted requester's word slice
   always_comb begin
      w_word = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_gnt_id == ID_W'(i)) w_word = data[i*WORD_W +: WORD_W];
      end
   end

   // service FSM next-state and core controls
   always_comb begin
      w_next      = r_state;
      w_core_sclr = 1'b0;
      w_core_en   = 1'b0;
      case (r_state)
         IDLE:  if (w_gnt_vld) w_next = LOAD;
         LOAD:  begin
            w_core_sclr = 1'b1;
            w_next      = SHIFT;
         end
         SHIFT: begin
            w_core_en = 1'b1;
            if (r_bit == CNT_W'(WORD_W - 1)) w_next = DRAIN;
         end
         DRAIN: w_next = DONE;
         DONE:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // service FSM state register
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) r_state <= IDLE;
      else      r_state <= w_next;
   end

   seq_detect_core u_core (
      .clk  (clk),
      .clr  (clr),
      .sclr (w_core_sclr),
      .en   (w_core_en),
      .w    (r_word[WORD_W-1]),
      .out  (w_core_out)
   );

   // core output describes the previous step, so step 0 never samples; DRAIN catches the last bit
   assign w_sample = w_core_out &&
                     (((r_state == SHIFT) && (r_bit != '0)) || (r_state == DRAIN));

   // grant latch, shift register, bit counter and hit counter
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_ptr     <= ID_W'(N_REQ - 1);
         r_id      <= '0;
         r_word    <= '0;
         r_bit     <= '0;
         r_hit_cnt <= '0;
      end else begin
         case (r_state)
            IDLE: if (w_gnt_vld) begin
               r_id   <= w_gnt_id;
               r_ptr  <= w_gnt_id;
               r_word <= w_word;
            end
            LOAD: begin
               r_bit     <= '0;
               r_hit_cnt <= '0;
            end
            SHIFT: begin
               r_word <= r_word << 1;
               r_bit  <= r_bit + CNT_W'(1);
               if (w_sample) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
            end
            DRAIN: if (w_sample) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
            default: ;
         endcase
      end
   end

`ifdef HIT_MASK_EN
   logic [WORD_W-1:0] r_mask;

   // hit flag for step k lands on bit WORD_W-1-k; r_bit is k+1 when it is sampled
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_mask <= '0;
      end else if (r_state == LOAD) begin
         r_mask <= '0;
      end else if (w_sample) begin
         r_mask <= r_mask | (WORD_W'(1) << (CNT_W'(WORD_W) - r_bit));
      end
   end

   assign hit_mask = r_mask;
`endif

   assign busy    = (r_state != IDLE);
   assign done    = (r_state == DONE);
   assign ack     = (r_state == DONE) ? (N_REQ'(1) << r_id) : '0;
   assign done_id = r_id;
   assign hit_cnt = r_hit_cnt;

endmodule
